// File: rtl/instr_enc_pkg.sv
// Shared definitions for the RV32I instruction encoder: field widths,
// major opcodes, the format type code (shared with the immediate decoder),
// the NOP word and the stage-1 request payload.
package instr_enc_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned F7_W   = 7;
  localparam int unsigned TYPE_W = 3;
  localparam int unsigned CNT_W  = 16;

  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;

  // addi x0,x0,0 - emitted in place of any unencodable request
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [TYPE_W-1:0] {
    TYPE_NONE = 3'd0,
    TYPE_I    = 3'd1,
    TYPE_S    = 3'd2,
    TYPE_B    = 3'd3,
    TYPE_U    = 3'd4,
    TYPE_J    = 3'd5
  } instr_type_e;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [F3_W-1:0]  funct3;
    logic [XLEN-1:0]  imm;
  } enc_req_t;

endpackage

// File: rtl/instr_encoder_if.sv
// Request/result handshake bundle of the instruction encoder.
// master: requester + result consumer; slave: the encoder.
interface instr_encoder_if;
  import instr_enc_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OPC_W-1:0]  in_opcode;
  logic [REG_W-1:0]  in_rd;
  logic [REG_W-1:0]  in_rs1;
  logic [REG_W-1:0]  in_rs2;
  logic [F3_W-1:0]   in_funct3;
  logic [F7_W-1:0]   in_funct7;
  logic [XLEN-1:0]   in_imm;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_instr;
  instr_type_e       out_type;
  logic              out_err;

  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
           in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_type, out_err
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
           in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_type, out_err
  );

endinterface

// File: rtl/instr_pack.sv
// Combinational format decode, encodability check and field packing.
// Ports: req (registered request) -> instr_c (packed word or NOP),
//        type_c (format code), err_c (unknown opcode or unencodable imm).
module instr_pack
  import instr_enc_pkg::*;
(
  input  enc_req_t          req,
  output logic [XLEN-1:0]   instr_c,
  output instr_type_e       type_c,
  output logic              err_c
);

  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] packed_c;
  logic            ok_c;

  assign imm = req.imm;

  always_comb begin
    type_c   = TYPE_NONE;
    ok_c     = 1'b0;
    packed_c = NOP_INSTR;

    case (req.opcode)
      OPC_OP_IMM, OPC_LOAD: type_c = TYPE_I;
      OPC_STORE:            type_c = TYPE_S;
      OPC_BRANCH:           type_c = TYPE_B;
      OPC_LUI, OPC_AUIPC:   type_c = TYPE_U;
      OPC_JAL:              type_c = TYPE_J;
      default:              type_c = TYPE_NONE;
    endcase

    // Encodable when the dropped upper bits are pure sign extension of the
    // top kept bit, and any implied-zero low bits are actually zero.
    case (type_c)
      TYPE_I: begin
        ok_c     = (imm[31:11] == {21{imm[11]}});
        packed_c = {imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
      end
      TYPE_S: begin
        ok_c     = (imm[31:11] == {21{imm[11]}});
        packed_c = {imm[11:5], req.rs2, req.rs1, req.funct3, imm[4:0], req.opcode};
      end
      TYPE_B: begin
        ok_c     = (imm[31:12] == {20{imm[12]}}) && !imm[0];
        packed_c = {imm[12], imm[10:5], req.rs2, req.rs1, req.funct3,
                    imm[4:1], imm[11], req.opcode};
      end
      TYPE_U: begin
        ok_c     = (imm[11:0] == 12'h000);
        packed_c = {imm[31:12], req.rd, req.opcode};
      end
      TYPE_J: begin
        ok_c     = (imm[31:20] == {12{imm[20]}}) && !imm[0];
        packed_c = {imm[20], imm[10:1], imm[11], imm[19:12], req.rd, req.opcode};
      end
      default: begin
        ok_c     = 1'b0;
        packed_c = NOP_INSTR;
      end
    endcase

    err_c   = !ok_c;
    instr_c = ok_c ? packed_c : NOP_INSTR;
  end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage RV32I instruction assembler with valid/ready on both sides.
// Ports: clk, rst (sync, active-high), bus (request in / encoded word out),
//        enc_count (delivered results), err_count (delivered errors).
module instr_encoder
  import instr_enc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  instr_encoder_if.slave   bus,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  logic            s1_valid;
  enc_req_t        s1_req;
  logic            s2_valid;
  logic [XLEN-1:0] s2_instr;
  instr_type_e     s2_type;
  logic            s2_err;

  logic            s2_adv_c;
  logic            in_fire_c;
  logic            out_fire_c;

  logic [XLEN-1:0] pack_instr_c;
  instr_type_e     pack_type_c;
  logic            pack_err_c;

  // funct7 carries no information for any supported format
  logic            unused_funct7;
  assign unused_funct7 = ^bus.in_funct7;

  // Stage 2 drains whenever it is empty or its result is being taken.
  assign s2_adv_c   = !s2_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_adv_c;
  assign in_fire_c  = bus.in_valid && bus.in_ready;
  assign out_fire_c = s2_valid && bus.out_ready;

  assign bus.out_valid = s2_valid;
  assign bus.out_instr = s2_instr;
  assign bus.out_type  = s2_type;
  assign bus.out_err   = s2_err;

  instr_pack u_pack (
    .req     (s1_req),
    .instr_c (pack_instr_c),
    .type_c  (pack_type_c),
    .err_c   (pack_err_c)
  );

  // Pipeline stages and delivery counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_req    <= '0;
      s2_valid  <= 1'b0;
      s2_instr  <= '0;
      s2_type   <= TYPE_NONE;
      s2_err    <= 1'b0;
      enc_count <= '0;
      err_count <= '0;
    end else begin
      if (s2_adv_c) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_instr <= pack_instr_c;
          s2_type  <= pack_type_c;
          s2_err   <= pack_err_c;
        end
      end

      if (bus.in_ready) begin
        s1_valid <= bus.in_valid;
        if (in_fire_c) begin
          s1_req.opcode <= bus.in_opcode;
          s1_req.rd     <= bus.in_rd;
          s1_req.rs1    <= bus.in_rs1;
          s1_req.rs2    <= bus.in_rs2;
          s1_req.funct3 <= bus.in_funct3;
          s1_req.imm    <= bus.in_imm;
        end
      end

      if (out_fire_c) begin
        enc_count <= enc_count + CNT_W'(1);
        if (s2_err) begin
          err_count <= err_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder.
module tb_instr_encoder;
  import instr_enc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] enc_count;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  instr_encoder_if bus ();

  instr_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [31:0] instr;
    logic [2:0]  typ;
    logic        err;
  } vec_t;

  vec_t        vecs [8];
  int          checks;
  int          passed;
  logic [15:0] exp_enc;
  logic [15:0] exp_err;

  task automatic init_vectors();
    vecs[0] = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 3'd1, 1'b0}; // addi x1,x0,-1
    vecs[1] = '{7'h23, 5'd7, 5'd1, 5'd2, 3'd2, 32'h0000_0008, 32'h0020_A423, 3'd2, 1'b0}; // sw x2,8(x1)
    vecs[2] = '{7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 3'd3, 1'b0}; // beq x0,x0,-4
    vecs[3] = '{7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000, 32'h1234_52B7, 3'd4, 1'b0}; // lui x5
    vecs[4] = '{7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0800, 32'h0010_00EF, 3'd5, 1'b0}; // jal x1,0x800
    vecs[5] = '{7'h63, 5'd0, 5'd3, 5'd4, 3'd0, 32'h0000_0003, 32'h0000_0013, 3'd3, 1'b1}; // B odd imm
    vecs[6] = '{7'h13, 5'd2, 5'd1, 5'd0, 3'd0, 32'h0000_0800, 32'h0000_0013, 3'd1, 1'b1}; // I imm too big
    vecs[7] = '{7'h00, 5'd1, 5'd1, 5'd1, 3'd0, 32'h0000_0000, 32'h0000_0013, 3'd0, 1'b1}; // unknown opcode
  endtask

  task automatic drive_req(input int i);
    bus.in_valid  = 1'b1;
    bus.in_opcode = vecs[i].op;
    bus.in_rd     = vecs[i].rd;
    bus.in_rs1    = vecs[i].rs1;
    bus.in_rs2    = vecs[i].rs2;
    bus.in_funct3 = vecs[i].f3;
    bus.in_funct7 = 7'h7F;
    bus.in_imm    = vecs[i].imm;
  endtask

  task automatic drive_idle();
    bus.in_valid  = 1'b0;
    bus.in_opcode = 7'h00;
    bus.in_imm    = 32'hDEAD_BEEF;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); else passed++;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); else passed++;
    checks++; if (bus.out_instr !== 32'h0) $display("FAIL reset_out_instr got=%h exp=0", bus.out_instr); else passed++;
    checks++; if (bus.out_type !== 3'd0) $display("FAIL reset_out_type got=%0d exp=0", bus.out_type); else passed++;
    checks++; if (bus.out_err !== 1'b0) $display("FAIL reset_out_err got=%b exp=0", bus.out_err); else passed++;
    checks++; if (enc_count !== 16'h0) $display("FAIL reset_enc_count got=%0d exp=0", enc_count); else passed++;
    checks++; if (err_count !== 16'h0) $display("FAIL reset_err_count got=%0d exp=0", err_count); else passed++;
    exp_enc = 16'h0;
    exp_err = 16'h0;
  endtask

  // One request through an empty pipeline: latency, result fields, counters.
  task automatic test_vector(input int i);
    @(posedge clk); #1;
    drive_req(i);
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL vec%0d_accept in_ready got=%b exp=1", i, bus.in_ready); else passed++;
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL vec%0d_lat_n1 out_valid got=%b exp=0", i, bus.out_valid); else passed++;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) $display("FAIL vec%0d_lat_n2 out_valid got=%b exp=1", i, bus.out_valid); else passed++;
    checks++; if (bus.out_instr !== vecs[i].instr) $display("FAIL vec%0d_instr got=%h exp=%h", i, bus.out_instr, vecs[i].instr); else passed++;
    checks++; if (bus.out_type !== vecs[i].typ) $display("FAIL vec%0d_type got=%0d exp=%0d", i, bus.out_type, vecs[i].typ); else passed++;
    checks++; if (bus.out_err !== vecs[i].err) $display("FAIL vec%0d_err got=%b exp=%b", i, bus.out_err, vecs[i].err); else passed++;
    exp_enc = exp_enc + 16'd1;
    exp_err = exp_err + 16'(vecs[i].err);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL vec%0d_drained out_valid got=%b exp=0", i, bus.out_valid); else passed++;
    checks++; if (enc_count !== exp_enc) $display("FAIL vec%0d_enc_count got=%0d exp=%0d", i, enc_count, exp_enc); else passed++;
    checks++; if (err_count !== exp_err) $display("FAIL vec%0d_err_count got=%0d exp=%0d", i, err_count, exp_err); else passed++;
  endtask

  // Full-rate streaming with out_ready high: one accept and one result per cycle.
  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      if (k < 5) drive_req(k); else drive_idle();
      @(negedge clk);
      if (k < 5) begin
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_in_ready cyc=%0d got=%b exp=1", k, bus.in_ready); else passed++;
      end
      if (k >= 2) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_instr !== vecs[k-2].instr)
          $display("FAIL b2b_out cyc=%0d got valid=%b instr=%h exp valid=1 instr=%h", k, bus.out_valid, bus.out_instr, vecs[k-2].instr);
        else passed++;
      end
    end
    exp_enc = exp_enc + 16'd5;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_drained out_valid got=%b exp=0", bus.out_valid); else passed++;
    checks++; if (enc_count !== exp_enc) $display("FAIL b2b_enc_count got=%0d exp=%0d", enc_count, exp_enc); else passed++;
  endtask

  // Output stalled: two accepts fill the pipe, then in_ready drops and the head holds.
  task automatic test_backpressure();
    int acc;
    acc = 0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      drive_req(acc);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) acc++;
      if (k >= 2) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_instr !== vecs[0].instr || bus.out_type !== vecs[0].typ)
          $display("FAIL bp_hold cyc=%0d got valid=%b instr=%h type=%0d exp valid=1 instr=%h type=%0d",
                   k, bus.out_valid, bus.out_instr, bus.out_type, vecs[0].instr, vecs[0].typ);
        else passed++;
      end
    end
    checks++; if (acc !== 2) $display("FAIL bp_accepts got=%0d exp=2", acc); else passed++;
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready); else passed++;
    @(posedge clk); #1;
    drive_idle();
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== vecs[0].instr) $display("FAIL bp_drain0 got valid=%b instr=%h exp instr=%h", bus.out_valid, bus.out_instr, vecs[0].instr); else passed++;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== vecs[1].instr) $display("FAIL bp_drain1 got valid=%b instr=%h exp instr=%h", bus.out_valid, bus.out_instr, vecs[1].instr); else passed++;
    exp_enc = exp_enc + 16'd2;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL bp_empty out_valid got=%b exp=0", bus.out_valid); else passed++;
    checks++; if (enc_count !== exp_enc) $display("FAIL bp_enc_count got=%0d exp=%0d", enc_count, exp_enc); else passed++;
  endtask

  // Eight requests with random out_ready: in order, no loss, no duplication.
  task automatic test_stream();
    int          sent;
    int          recv;
    int          cyc;
    logic [15:0] start_enc;
    sent = 0;
    recv = 0;
    cyc  = 0;
    start_enc = exp_enc;
    while (recv < 8 && cyc < 300) begin
      @(posedge clk); #1;
      if (sent < 8) drive_req(sent); else drive_idle();
      bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.out_valid) begin
        checks++;
        if (recv >= 8) begin
          $display("FAIL stream_extra got instr=%h exp no output", bus.out_instr);
        end else if ({bus.out_instr, bus.out_type, bus.out_err} !== {vecs[recv].instr, vecs[recv].typ, vecs[recv].err}) begin
          $display("FAIL stream_item%0d got instr=%h type=%0d err=%b exp instr=%h type=%0d err=%b",
                   recv, bus.out_instr, bus.out_type, bus.out_err, vecs[recv].instr, vecs[recv].typ, vecs[recv].err);
        end else passed++;
        if (bus.out_ready && recv < 8) begin
          exp_enc = exp_enc + 16'd1;
          exp_err = exp_err + 16'(vecs[recv].err);
          recv++;
        end
      end
      if (bus.in_valid && bus.in_ready) sent++;
      cyc++;
    end
    checks++; if (recv !== 8) $display("FAIL stream_timeout received=%0d exp=8", recv); else passed++;
    @(posedge clk); #1;
    drive_idle();
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (enc_count !== start_enc + 16'd8) $display("FAIL stream_enc_count got=%0d exp=%0d", enc_count, start_enc + 16'd8); else passed++;
    checks++; if (err_count !== exp_err) $display("FAIL stream_err_count got=%0d exp=%0d", err_count, exp_err); else passed++;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL stream_drained out_valid got=%b exp=0", bus.out_valid); else passed++;
  endtask

  // Reset with both stages full discards them and clears the counters.
  task automatic test_reset_midstream();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      drive_req(k + 2);
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b1) $display("FAIL rstmid_fill%0d in_ready got=%b exp=1", k, bus.in_ready); else passed++;
    end
    @(posedge clk); #1;
    drive_idle();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL rstmid_out_valid got=%b exp=0", bus.out_valid); else passed++;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL rstmid_in_ready got=%b exp=1", bus.in_ready); else passed++;
    checks++; if (enc_count !== 16'h0) $display("FAIL rstmid_enc_count got=%0d exp=0", enc_count); else passed++;
    checks++; if (err_count !== 16'h0) $display("FAIL rstmid_err_count got=%0d exp=0", err_count); else passed++;
    exp_enc = 16'h0;
    exp_err = 16'h0;
    test_vector(3);
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_opcode = 7'h00;
    bus.in_rd     = 5'd0;
    bus.in_rs1    = 5'd0;
    bus.in_rs2    = 5'd0;
    bus.in_funct3 = 3'd0;
    bus.in_funct7 = 7'd0;
    bus.in_imm    = 32'h0;
    bus.out_ready = 1'b0;
    init_vectors();

    test_reset();
    for (int i = 0; i < 8; i++) test_vector(i);
    test_back_to_back();
    test_backpressure();
    test_stream();
    test_reset_midstream();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
